d5m_pattern_source: RTL

D5M_PATTERN_SOURCE -- requirements
Module: d5m_pattern_source

---
 rtl/d5m_pattern_source_pkg.sv | 31 +++
 rtl/d5m_pattern_gen.sv | 64 ++++++
 rtl/d5m_pattern_source.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/d5m_pattern_source_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d5m_pattern_source_pkg
// Brief    : Shared types and constants for the D5M test-pattern source:
//            pattern selector, FSM state encoding and the pixel width.
// Revision : 1.0 - initial release
// ============================================================================
package d5m_pattern_source_pkg;

  // Width of one D5M pixel sample (D[11:0])
  localparam int c_PIXEL_W = 12;

  // Test pattern selector, encoded as on the ul2Pattern input
  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } patternE;

  // Frame timing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } stateE;

endpackage
`default_nettype wire

// File: rtl/d5m_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : d5m_pattern_gen
// Brief    : Combinational pixel value for one (row, col) position of the
//            selected test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module d5m_pattern_gen
  import d5m_pattern_source_pkg::*;
#(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic [1:0]           pattern,
  input  logic [COL_W-1:0]     col,
  input  logic [ROW_W-1:0]     row,
  input  logic [2:0]           barIndex,
  input  logic [c_PIXEL_W-1:0] solidLevel,
  output logic [c_PIXEL_W-1:0] pixel
);

  logic                 w_colBit3;
  logic                 w_rowBit3;
  logic [c_PIXEL_W-1:0] w_ramp;
  logic                 w_unusedRow;
  logic                 w_unusedCol;

  // Only bit 3 of row and the low bits of col matter to the patterns
  assign w_unusedRow = ^row;
  assign w_unusedCol = ^col;

  if (COL_W > 3) begin : g_colBit3
    assign w_colBit3 = col[3];
  end else begin : g_colBit3Narrow
    assign w_colBit3 = 1'b0;
  end

  if (ROW_W > 3) begin : g_rowBit3
    assign w_rowBit3 = row[3];
  end else begin : g_rowBit3Narrow
    assign w_rowBit3 = 1'b0;
  end

  // Ramp is the column number modulo 4096
  if (COL_W >= c_PIXEL_W) begin : g_rampWide
    assign w_ramp = col[c_PIXEL_W-1:0];
  end else begin : g_rampNarrow
    assign w_ramp = {{(c_PIXEL_W-COL_W){1'b0}}, col};
  end

  // Select the pattern; bars put the 3-bit index in every nibble (0x111 * i)
  always_comb begin
    pixel = '0;
    case (patternE'(pattern))
      PAT_RAMP:    pixel = w_ramp;
      PAT_BARS:    pixel = {1'b0, barIndex, 1'b0, barIndex, 1'b0, barIndex};
      PAT_CHECKER: pixel = (w_colBit3 ^ w_rowBit3) ? '1 : '0;
      PAT_SOLID:   pixel = solidLevel;
      default:     pixel = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/d5m_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : d5m_pattern_source
// Brief    : Transmit end of the D5M parallel pixel interface. Produces
//            FVAL/LVAL/D[11:0] frames carrying a selectable test pattern.
//            Optional macro D5M_PATTERN_SOURCE_FRAME_COUNT_EN replaces pixel
//            (0,0) of each frame with a 12-bit wrapping frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module d5m_pattern_source
  import d5m_pattern_source_pkg::*;
#(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int HBLANK      = 160,
  parameter int VBLANK      = 45,
  parameter int SOF_GAP     = 4
) (
  input  logic                 ul1Clock,
  input  logic                 ul1ResetN,
  input  logic                 ul1Enable,
  input  logic [1:0]           ul2Pattern,
  input  logic [c_PIXEL_W-1:0] ul12SolidValue,
  output logic                 ul1FrameValid,
  output logic                 ul1LineValid,
  output logic [c_PIXEL_W-1:0] ul12PixelData,
  output logic                 ul1Busy
);

  localparam int c_COL_W     = (ACTIVE_COLS > 1) ? $clog2(ACTIVE_COLS) : 1;
  localparam int c_ROW_W     = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
  localparam int c_BAR_LEN   = ACTIVE_COLS / 8;
  localparam int c_BARCNT_W  = (c_BAR_LEN > 1) ? $clog2(c_BAR_LEN) : 1;
  localparam int c_GAP_MAX   = (SOF_GAP > HBLANK) ?
                               ((SOF_GAP > VBLANK) ? SOF_GAP : VBLANK) :
                               ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int c_GAP_W     = (c_GAP_MAX > 1) ? $clog2(c_GAP_MAX) : 1;

  localparam logic [c_COL_W-1:0]    c_COL_LAST = c_COL_W'(ACTIVE_COLS - 1);
  localparam logic [c_ROW_W-1:0]    c_ROW_LAST = c_ROW_W'(ACTIVE_ROWS - 1);
  localparam logic [c_BARCNT_W-1:0] c_BAR_LAST = c_BARCNT_W'(c_BAR_LEN - 1);
  localparam logic [c_GAP_W-1:0]    c_SOF_LAST = c_GAP_W'(SOF_GAP - 1);
  localparam logic [c_GAP_W-1:0]    c_HB_LAST  = c_GAP_W'(HBLANK - 1);
  localparam logic [c_GAP_W-1:0]    c_VB_LAST  = c_GAP_W'(VBLANK - 1);

  stateE                 r_state;
  logic [c_COL_W-1:0]    r_col;
  logic [c_ROW_W-1:0]    r_row;
  logic [2:0]            r_bar;
  logic [c_BARCNT_W-1:0] r_barCnt;
  logic [c_GAP_W-1:0]    r_gapCnt;
  logic [1:0]            r_pattern;
  logic [c_PIXEL_W-1:0]  r_solid;
  logic                  r_fval;
  logic                  r_lval;
  logic [c_PIXEL_W-1:0]  r_data;
  logic                  r_busy;

  logic [c_COL_W-1:0]    w_genCol;
  logic [c_ROW_W-1:0]    w_genRow;
  logic [2:0]            w_genBar;
  logic [c_PIXEL_W-1:0]  w_genPix;
  logic [c_PIXEL_W-1:0]  w_pixNext;

  // Coordinates of the pixel that will be on the bus after the next edge
  always_comb begin
    w_genCol = '0;
    w_genRow = r_row;
    w_genBar = 3'd0;
    if (r_state == ST_ACTIVE) begin
      w_genCol = r_col + 1'b1;
      w_genBar = (r_barCnt == c_BAR_LAST) ? r_bar + 3'd1 : r_bar;
    end else if (r_state == ST_HBLANK) begin
      w_genRow = r_row + 1'b1;
    end
  end

  d5m_pattern_gen #(
    .COL_W (c_COL_W),
    .ROW_W (c_ROW_W)
  ) u_gen (
    .pattern    (r_pattern),
    .col        (w_genCol),
    .row        (w_genRow),
    .barIndex   (w_genBar),
    .solidLevel (r_solid),
    .pixel      (w_genPix)
  );

`ifdef D5M_PATTERN_SOURCE_FRAME_COUNT_EN
  logic [c_PIXEL_W-1:0] r_frameCnt;

  // Count completed frames; bumps on every VBLANK exit
  always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
    if (!ul1ResetN) begin
      r_frameCnt <= '0;
    end else if (r_state == ST_VBLANK && r_gapCnt == c_VB_LAST) begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  // Pixel (0,0) is only ever loaded from SOF, so it carries the count
  assign w_pixNext = (r_state == ST_SOF) ? r_frameCnt : w_genPix;
`else
  assign w_pixNext = w_genPix;
`endif

  // Frame timing FSM with registered D5M outputs
  always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
    if (!ul1ResetN) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_bar     <= '0;
      r_barCnt  <= '0;
      r_gapCnt  <= '0;
      r_pattern <= '0;
      r_solid   <= '0;
      r_fval    <= 1'b0;
      r_lval    <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ul1Enable) begin
            r_state   <= ST_SOF;
            r_gapCnt  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pattern <= ul2Pattern;
            r_solid   <= ul12SolidValue;
            r_fval    <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_SOF: begin
          if (r_gapCnt == c_SOF_LAST) begin
            r_state  <= ST_ACTIVE;
            r_col    <= '0;
            r_bar    <= '0;
            r_barCnt <= '0;
            r_lval   <= 1'b1;
            r_data   <= w_pixNext;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (r_col == c_COL_LAST) begin
            r_state  <= ST_HBLANK;
            r_gapCnt <= '0;
            r_lval   <= 1'b0;
            r_data   <= '0;
          end else begin
            r_col    <= w_genCol;
            r_bar    <= w_genBar;
            r_barCnt <= (r_barCnt == c_BAR_LAST) ? '0 : r_barCnt + 1'b1;
            r_data   <= w_pixNext;
          end
        end
        ST_HBLANK: begin
          if (r_gapCnt == c_HB_LAST) begin
            r_gapCnt <= '0;
            if (r_row == c_ROW_LAST) begin
              r_state <= ST_VBLANK;
              r_fval  <= 1'b0;
            end else begin
              r_state  <= ST_ACTIVE;
              r_row    <= w_genRow;
              r_col    <= '0;
              r_bar    <= '0;
              r_barCnt <= '0;
              r_lval   <= 1'b1;
              r_data   <= w_pixNext;
            end
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (r_gapCnt == c_VB_LAST) begin
            r_gapCnt <= '0;
            if (ul1Enable) begin
              r_state   <= ST_SOF;
              r_row     <= '0;
              r_col     <= '0;
              r_pattern <= ul2Pattern;
              r_solid   <= ul12SolidValue;
              r_fval    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fval  <= 1'b0;
          r_lval  <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ul1FrameValid = r_fval;
  assign ul1LineValid  = r_lval;
  assign ul12PixelData = r_data;
  assign ul1Busy       = r_busy;

endmodule
`default_nettype wire
